// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 command transmitter.
//
// Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to a PS/2 device.
// Both bus lines are open-drain. The *_oe outputs are pull-low enables that
// the top level turns into tri-states. The block never drives a line high.
//
// Ports:
//   clk       system clock (CLOCK_50 domain)
//   reset     asynchronous, active-high; releases both lines and returns to IDLE
//   tx_data   command byte, latched when a start is accepted
//   tx_start  single-cycle start request
//   ps2c_in   raw PS/2 clock line level
//   ps2d_in   raw PS/2 data line level
//   ps2c_oe   1 = pull the clock line low
//   ps2d_oe   1 = pull the data line low
//   busy      high from start acceptance until the done/error pulse cycle
//   tx_done   one-cycle pulse: frame sent and ACKed by the device
//   tx_error  one-cycle pulse: timeout or missing ACK
//
// Start handshake: tx_start is a request strobe with no back-pressure. It is
// taken only while the FSM is in IDLE (busy = 0 and no done/error pulse in
// that cycle). A strobe at any other time is dropped, never queued.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int FW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_WAIT_IDLE, S_DONE, S_ERROR
  } state_t;

  // ---------------------------------------------------------------- input conditioning
  logic [1:0]    c_sync_q, d_sync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall_q, fall_d;
  logic          c_s, d_s;

  assign c_s = c_sync_q[1];
  assign d_s = d_sync_q[1];

  // Synchronizers and filter reset to the idle (released, high) level so
  // that leaving reset never produces a spurious falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      fall_q   <= 1'b0;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2c_in};
      d_sync_q <= {d_sync_q[0], ps2d_in};
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      fall_q   <= fall_d;
    end
  end

  // The counter tracks how many consecutive samples disagree with the
  // filtered level; any agreeing sample restarts it.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (c_s != filt_q) begin
      if (fcnt_q == FLT_LAST) filt_d = c_s;
      else                    fcnt_d = fcnt_q + FW'(1);
    end
    fall_d = filt_q & ~filt_d;
  end

  // ---------------------------------------------------------------- FSM + datapath
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;     // inhibit length, then device-edge timeout
  logic [3:0]    idx_q, idx_d;     // falling edges consumed in SEND
  logic [8:0]    sh_q, sh_d;       // {parity, data}, shifted out LSB first
  logic          dat_oe_q, dat_oe_d;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_q     <= '0;
      dat_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sh_q     <= sh_d;
      dat_oe_q <= dat_oe_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    dat_oe_d = dat_oe_q;
    unique case (state_q)
      S_IDLE: begin
        dat_oe_d = 1'b0;
        if (tx_start) begin
          sh_d    = {~^tx_data, tx_data};  // odd parity
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d   = '0;
          state_d = S_REQ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_REQ: begin
        // Start bit stays low across the hand-over into SEND.
        dat_oe_d = 1'b1;
        cnt_d    = '0;
        idx_d    = '0;
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (fall_q) begin
          cnt_d = '0;
          if (idx_q < 4'd9) begin
            dat_oe_d = ~sh_q[0];
            sh_d     = {1'b0, sh_q[8:1]};
            idx_d    = idx_q + 4'd1;
          end else if (idx_q == 4'd9) begin
            dat_oe_d = 1'b0;               // stop bit: release the line
            idx_d    = 4'd10;
          end else begin
            // ACK edge: the device must be holding data low.
            state_d = d_s ? S_ERROR : S_WAIT_IDLE;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (filt_q && d_s) begin
          state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERROR: begin
        dat_oe_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode from the state register only, so an asynchronous reset
  // releases both lines immediately.
  always_comb begin
    ps2c_oe  = 1'b0;
    ps2d_oe  = 1'b0;
    busy     = 1'b0;
    tx_done  = 1'b0;
    tx_error = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_INHIBIT: begin
        ps2c_oe = 1'b1;
        busy    = 1'b1;
      end
      S_REQ: begin
        ps2c_oe = 1'b1;
        ps2d_oe = 1'b1;
        busy    = 1'b1;
      end
      S_SEND: begin
        ps2d_oe = dat_oe_q;
        busy    = 1'b1;
      end
      S_WAIT_IDLE: begin
        busy = 1'b1;
      end
      S_DONE:  tx_done  = 1'b1;
      S_ERROR: tx_error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- bench for ps2_host_tx with a behavioural PS/2 device.
// The device model clocks the bus, samples each host bit before its rising
// edge and compares it with the bit expected for the byte that was started.
module tb_ps2_host_tx;

  localparam int INHIBIT = 50;
  localparam int TIMEOUT = 2000;
  localparam int FLEN    = 8;
  localparam int HALF    = 100;  // device clock half period in system cycles

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe;
  logic       busy, tx_done, tx_error;
  logic       dev_clk, dev_dat;   // device side: 1 = released

  // Wired-AND open-drain bus with pull-ups
  assign ps2c_in = dev_clk & ~ps2c_oe;
  assign ps2d_in = dev_dat & ~ps2d_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INHIBIT),
    .TIMEOUT_CYCLES(TIMEOUT),
    .FILTER_LEN    (FLEN)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .ps2c_in (ps2c_in),
    .ps2d_in (ps2d_in),
    .ps2c_oe (ps2c_oe),
    .ps2d_oe (ps2d_oe),
    .busy    (busy),
    .tx_done (tx_done),
    .tx_error(tx_error)
  );

  // ---------------------------------------------------------------- clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------------------------------------------------------- scoreboard
  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tx_done)  done_cnt++;
    if (tx_error) err_cnt++;
  end

  // ---------------------------------------------------------------- driver tasks
  // Pulse tx_start, push the expected frame bits, and measure the inhibit.
  task automatic start_tx(input logic [7:0] b);
    int   cnt;
    logic last_d;
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back({31'd0, b[i]});
    exp_q.push_back(($countones(b) % 2 == 0) ? 32'd1 : 32'd0);  // odd parity
    exp_q.push_back(32'd1);                                      // stop
    @(posedge clk);
    #1;
    check("busy_after_start", busy, 1);
    check("clk_inhibit_start", ps2c_oe, 1);
    tx_start = 1'b0;
    cnt    = 0;
    last_d = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!ps2c_oe) break;
      cnt++;
      last_d = ps2d_oe;
    end
    check("inhibit_len", cnt, INHIBIT + 1);
    check("req_data_low", last_d, 1);
  endtask

  // Behavioural device: wait for the request, then generate nclk clocks.
  task automatic dev_frame(input bit ack, input bit glitch, input int nclk);
    int          guard;
    logic        b;
    logic [31:0] e;
    guard = 0;
    while (!(ps2c_in === 1'b1 && ps2d_in === 1'b0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("request_seen", (guard < 200), 1);
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= nclk; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (k <= 10) begin
        b = ps2d_in;
        if (exp_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("frame_bit", {31'd0, b}, e);
        end
      end
      dev_clk = 1'b1;
      if (k == 10 && ack) dev_dat = 1'b0;
      if (glitch && k >= 2 && k <= 6) begin
        repeat (HALF / 2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF - HALF / 2 - 3) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    dev_dat = 1'b1;
  endtask

  // Wait for the completion pulse; optionally poke tx_start in the pulse cycle.
  task automatic wait_pulse(input bit poke, output bit d, output bit e);
    bit seen;
    seen = 1'b0;
    d    = 1'b0;
    e    = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (tx_done || tx_error) begin
        seen = 1'b1;
        break;
      end
    end
    check("pulse_seen", seen, 1);
    if (seen) begin
      d = tx_done;
      e = tx_error;
      check("busy_at_pulse", busy, 0);
      check("lines_released_at_pulse", {ps2c_oe, ps2d_oe}, 0);
      if (poke) begin
        tx_data  = 8'hAA;
        tx_start = 1'b1;
      end
      @(negedge clk);
      tx_start = 1'b0;
      check("pulse_one_cycle", {tx_done, tx_error}, 0);
      if (poke) begin
        check("start_at_pulse_ignored_busy", busy, 0);
        check("start_at_pulse_ignored_clk", ps2c_oe, 0);
      end
    end
  endtask

  task automatic send_ok(input logic [7:0] b, input bit glitch, input bit poke);
    bit d, e;
    int d0;
    d0 = done_cnt;
    start_tx(b);
    fork
      dev_frame(1'b1, glitch, 11);
      wait_pulse(poke, d, e);
    join
    check("done_pulse", d, 1);
    check("no_error_pulse", e, 0);
    check("done_count", done_cnt - d0, 1);
  endtask

  // ---------------------------------------------------------------- main sequence
  initial begin
    bit d, e;
    int n, d0, e0;
    reset    = 1'b1;
    tx_data  = 8'h00;
    tx_start = 1'b0;
    dev_clk  = 1'b1;
    dev_dat  = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_clk_oe", ps2c_oe, 0);
    check("rst_dat_oe", ps2d_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_error", tx_error, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Set-LEDs command, with a start poked during the done pulse
    send_ok(8'hED, 1'b0, 1'b1);
    repeat (20) @(negedge clk);

    // Parity corners
    send_ok(8'h01, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    send_ok(8'hFF, 1'b0, 1'b0);
    repeat (20) @(negedge clk);

    // Device never ACKs
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'hA5);
    fork
      dev_frame(1'b0, 1'b0, 11);
      wait_pulse(1'b0, d, e);
    join
    check("noack_error_pulse", e, 1);
    check("noack_no_done", d, 0);
    check("noack_error_count", err_cnt - e0, 1);
    check("noack_done_count", done_cnt - d0, 0);
    repeat (20) @(negedge clk);

    // Glitches on the clock line plus a start strobe while busy
    fork
      send_ok(8'h3A, 1'b1, 1'b0);
      begin
        repeat (700) @(negedge clk);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("busy_start_still_busy", busy, 1);
      end
    join
    repeat (20) @(negedge clk);

    // Device silent after the request: timeout counted from SEND entry
    start_tx(8'hFF);
    exp_q.delete();
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      if (tx_error) break;
      n++;
      @(negedge clk);
    end
    check("silent_timeout_cycles", n, TIMEOUT);
    check("silent_error_pulse", tx_error, 1);
    repeat (20) @(negedge clk);

    // Reset in the middle of a frame (D4 of 0x0C is 0, so data is pulled low)
    start_tx(8'h0C);
    dev_frame(1'b1, 1'b0, 5);
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    check("dat_low_before_reset", ps2d_oe, 1);
    #3 reset = 1'b1;
    #1;
    check("async_rst_clk_oe", ps2c_oe, 0);
    check("async_rst_dat_oe", ps2d_oe, 0);
    check("async_rst_busy", busy, 0);
    exp_q.delete();
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (HALF) @(negedge clk);
    check("reset_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);

    // Normal transfer after the aborted one
    send_ok(8'hF4, 1'b0, 1'b0);
    repeat (20) @(negedge clk);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
